xadac_obi_arbiter: RTL

XADAC_OBI_ARBITER -- requirements
Module: xadac_obi_arbiter

---
 rtl/xadac_pkg.sv | 15 +
 rtl/xadac_rr_pick.sv | 40 ++++
 rtl/xadac_obi_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/xadac_pkg.sv
// Shared XADAC types for the OBI fabric.
// Provides address/data/byte-enable/id types and the id width used by the
// arbiter and its managers.
package xadac_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned WordWidth = 32;
  localparam int unsigned IdWidth   = 4;

  typedef logic [AddrWidth-1:0]   AddrT;
  typedef logic [WordWidth-1:0]   WordT;
  typedef logic [WordWidth/8-1:0] BeT;
  typedef logic [IdWidth-1:0]     IdT;

endpackage

// File: rtl/xadac_rr_pick.sv
// Round-robin picker: returns the first set bit of req, searching upward from
// index start and wrapping at N.
// Ports:
//   req   - request vector
//   start - index with highest priority this cycle
//   gnt   - one-hot winner
//   idx   - binary winner index
//   valid - at least one request present
module xadac_rr_pick #(
  parameter  int unsigned N    = 2,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] start,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx,
  output logic            valid
);

  int unsigned cand;
  logic [N-1:0] req_sh;

  always_comb begin
    gnt    = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = 0;
    req_sh = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand   = (32'(start) + off) % N;
      req_sh = req >> cand;
      if (!valid && req_sh[0]) begin
        valid = 1'b1;
        idx   = IdxW'(cand);
        gnt   = N'(1) << cand;
      end
    end
  end

endmodule

// File: rtl/xadac_obi_arbiter.sv
// N-to-1 OBI arbiter with round-robin A-channel arbitration, per-manager
// outstanding-transaction limiting and R-channel routing by source id.
// Ports:
//   clk, rstn                 - clock, async active-low reset
//   mgr_req/gnt + payload     - per-manager A channel
//   mgr_rvalid/rready         - per-manager R handshake
//   mgr_rdata, mgr_rid        - R payload broadcast to all managers
//   sub_req/gnt + payload     - subordinate A channel; sub_aid = {src, aid}
//   sub_rvalid/rready/rdata/rid - subordinate R channel; sub_rid = {src, id}
module xadac_obi_arbiter
  import xadac_pkg::*;
#(
  parameter  int unsigned NumMgr   = 2,
  parameter  int unsigned MaxOutst = 4,
  localparam int unsigned SrcWidth = (NumMgr > 1) ? $clog2(NumMgr) : 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NumMgr-1:0]           mgr_req,
  output logic [NumMgr-1:0]           mgr_gnt,
  input  AddrT                        mgr_addr  [NumMgr],
  input  logic [NumMgr-1:0]           mgr_we,
  input  BeT                          mgr_be    [NumMgr],
  input  WordT                        mgr_wdata [NumMgr],
  input  IdT                          mgr_aid   [NumMgr],
  output logic [NumMgr-1:0]           mgr_rvalid,
  input  logic [NumMgr-1:0]           mgr_rready,
  output WordT                        mgr_rdata,
  output IdT                          mgr_rid,
  output logic                        sub_req,
  input  logic                        sub_gnt,
  output AddrT                        sub_addr,
  output logic                        sub_we,
  output BeT                          sub_be,
  output WordT                        sub_wdata,
  output logic [IdWidth+SrcWidth-1:0] sub_aid,
  input  logic                        sub_rvalid,
  output logic                        sub_rready,
  input  WordT                        sub_rdata,
  input  logic [IdWidth+SrcWidth-1:0] sub_rid
);

  localparam int unsigned CntW = $clog2(MaxOutst + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutst);

  logic [CntW-1:0]     cnt_q [NumMgr];
  logic [CntW-1:0]     cnt_d [NumMgr];
  logic [SrcWidth-1:0] rr_q, rr_d;
  logic [SrcWidth-1:0] lock_idx_q, lock_idx_d;
  logic                lock_q, lock_d;

  logic [NumMgr-1:0]   eligible, pick_gnt, win_oh, r_hs_vec;
  logic [SrcWidth-1:0] pick_idx, win_idx, rsp_src;
  logic                pick_valid, a_hs, rsp_ok;

  always_comb begin
    for (int i = 0; i < NumMgr; i++) begin
      eligible[i] = mgr_req[i] && (cnt_q[i] != CntMax);
    end
  end

  xadac_rr_pick #(
    .N (NumMgr)
  ) u_pick (
    .req   (eligible),
    .start (rr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // A stalled request keeps its manager selected until accepted, so the
  // payload seen by the subordinate cannot change mid-handshake.
  always_comb begin
    if (lock_q) begin
      win_idx = lock_idx_q;
      win_oh  = NumMgr'(1) << lock_idx_q;
      sub_req = mgr_req[lock_idx_q];
    end else begin
      win_idx = pick_idx;
      win_oh  = pick_gnt;
      sub_req = pick_valid;
    end
  end

  assign a_hs      = sub_req && sub_gnt;
  assign mgr_gnt   = win_oh & {NumMgr{a_hs}};
  assign sub_addr  = mgr_addr[win_idx];
  assign sub_we    = mgr_we[win_idx];
  assign sub_be    = mgr_be[win_idx];
  assign sub_wdata = mgr_wdata[win_idx];
  assign sub_aid   = {win_idx, mgr_aid[win_idx]};

  // R routing depends only on R inputs; nothing here feeds mgr_gnt.
  assign rsp_src    = sub_rid[IdWidth +: SrcWidth];
  assign rsp_ok     = 32'(rsp_src) < NumMgr;
  assign mgr_rvalid = NumMgr'(sub_rvalid && rsp_ok) << rsp_src;
  assign sub_rready = rsp_ok && mgr_rready[rsp_src];
  assign r_hs_vec   = mgr_rvalid & {NumMgr{sub_rready}};
  assign mgr_rdata  = sub_rdata;
  assign mgr_rid    = sub_rid[IdWidth-1:0];

  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (a_hs) begin
      rr_d   = (32'(win_idx) == NumMgr - 1) ? '0 : win_idx + SrcWidth'(1);
      lock_d = 1'b0;
    end else if (sub_req) begin
      lock_d     = 1'b1;
      lock_idx_d = win_idx;
    end else begin
      lock_d = 1'b0;
    end
  end

  // Simultaneous A and R for one manager cancel out; R on an empty counter
  // saturates at zero.
  always_comb begin
    for (int i = 0; i < NumMgr; i++) begin
      cnt_d[i] = cnt_q[i];
      if (mgr_gnt[i] && !r_hs_vec[i]) begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end else if (r_hs_vec[i] && !mgr_gnt[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      for (int i = 0; i < NumMgr; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      for (int i = 0; i < NumMgr; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < NumMgr; i++) begin
        assert (!(r_hs_vec[i] && !mgr_gnt[i] && (cnt_q[i] == '0)))
          else $error("xadac_obi_arbiter: R response to manager %0d with none outstanding", i);
      end
    end
  end

endmodule
